onehot_digit_sequencer: RTL and testbench

- Sequencer that generates the one-hot digit select consumed by the combinational one-hot-to-7-segment encoder on ui_in[7:0].
- Steps the selected digit automatically at a programmable rate (up or down), or manually from a debounced push-button, with hold and clear.
- Sits between the board inputs and the segment encoder inside the TT top; the encoder output is unchanged.

---
 rtl/onehot_digit_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_onehot_digit_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_digit_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : onehot_digit_sequencer
// Description : Generates the one-hot digit select for the one-hot to
//               7-segment encoder. The selected digit advances automatically
//               at a programmable rate (up or down) or manually from a
//               debounced push-button, with hold and synchronous clear.
//
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset
//               ena     - advance enable; 0 freezes state, prescaler, index
//               mode    - 00 HOLD, 01 AUTO_UP, 10 AUTO_DOWN, 11 MANUAL
//               step    - asynchronous push-button, active-high
//               period  - auto tick fires every period+1 enabled cycles
//               clear   - synchronous return to index 0 (highest priority)
//               code    - registered one-hot digit select
//               index   - registered binary index of the set code bit
//               tick    - one-cycle pulse on every advance
//               wrap    - one-cycle pulse when an advance wraps the index
//
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_digit_sequencer #(
  parameter int PRESCALE_W   = 24,
  parameter int DIGITS       = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  step,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  clear,
  output logic [7:0]            code,
  output logic [2:0]            index,
  output logic                  tick,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'b00,
    ST_AUTO_UP   = 2'b01,
    ST_AUTO_DOWN = 2'b10,
    ST_MANUAL    = 2'b11
  } state_t;

  localparam logic [2:0]            c_last_idx = 3'(DIGITS - 1);
  localparam logic [3:0]            c_db_last  = 4'(DEBOUNCE_CYC - 1);
  localparam logic [PRESCALE_W-1:0] c_cnt_one  = PRESCALE_W'(1);

  // --------------------------------------------------------------------------
  // Step path: 2-FF synchronizer, debouncer, rising-edge detector.
  // Runs regardless of ena so a level change seen while disabled is absorbed
  // and cannot appear as a fresh press once ena returns.
  // --------------------------------------------------------------------------
  logic       r_sync1;
  logic       r_sync2;
  logic       r_db_level;
  logic       r_db_prev;
  logic [3:0] r_db_cnt;
  logic       w_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= 4'd0;
    end else begin
      r_sync1   <= step;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      // Count consecutive samples that disagree with the accepted level;
      // any agreeing sample restarts the run.
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= 4'd0;
      end else if (r_db_cnt == c_db_last) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= 4'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 4'd1;
      end
    end
  end

  assign w_press = r_db_level & ~r_db_prev;

  // --------------------------------------------------------------------------
  // Sequencer: state register, prescaler, index/code and pulse outputs.
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [2:0]            r_index;
  logic [7:0]            r_code;
  logic                  r_tick;
  logic                  r_wrap;

  logic       w_terminal;
  logic       w_auto;
  logic       w_adv_up;
  logic       w_adv_dn;
  logic [2:0] w_next_index;
  logic       w_next_wrap;

  // Equality compare: a period lowered below the running count lets the
  // counter run on and wrap naturally instead of firing early.
  assign w_terminal = (r_cnt == period);
  assign w_auto     = (r_state == ST_AUTO_UP) || (r_state == ST_AUTO_DOWN);
  assign w_adv_up   = ena & (((r_state == ST_AUTO_UP) & w_terminal) |
                             ((r_state == ST_MANUAL)  & w_press));
  assign w_adv_dn   = ena & (r_state == ST_AUTO_DOWN) & w_terminal;

  always_comb begin
    w_next_index = r_index;
    w_next_wrap  = 1'b0;
    if (w_adv_up) begin
      if (r_index == c_last_idx) begin
        w_next_index = 3'd0;
        w_next_wrap  = 1'b1;
      end else begin
        w_next_index = r_index + 3'd1;
      end
    end else if (w_adv_dn) begin
      if (r_index == 3'd0) begin
        w_next_index = c_last_idx;
        w_next_wrap  = 1'b1;
      end else begin
        w_next_index = r_index - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_index <= 3'd0;
      r_code  <= 8'h01;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      if (ena) begin
        r_state <= state_t'(mode);
      end

      if (clear) begin
        // Clear wins over any coincident advance, even while disabled.
        r_cnt   <= '0;
        r_index <= 3'd0;
        r_code  <= 8'h01;
        r_tick  <= 1'b0;
        r_wrap  <= 1'b0;
      end else if (ena) begin
        // Entering a new state always starts the prescaler from zero.
        if (state_t'(mode) != r_state) begin
          r_cnt <= '0;
        end else if (w_auto) begin
          r_cnt <= w_terminal ? '0 : (r_cnt + c_cnt_one);
        end
        r_index <= w_next_index;
        r_code  <= 8'h01 << w_next_index;
        r_tick  <= w_adv_up | w_adv_dn;
        r_wrap  <= w_next_wrap;
      end else begin
        r_tick <= 1'b0;
        r_wrap <= 1'b0;
      end
    end
  end

  assign code  = r_code;
  assign index = r_index;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_onehot_digit_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_onehot_digit_sequencer
// Description : Self-checking bench for onehot_digit_sequencer: phase table,
//               hand-written multi-cycle sequences and randomized stimulus
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_digit_sequencer;

  localparam int PW     = 24;
  localparam int DIG    = 8;
  localparam int DEB    = 4;
  localparam int DIG5   = 5;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          ena    = 1'b0;
  logic [1:0]    mode   = 2'b00;
  logic          step   = 1'b0;
  logic [PW-1:0] period = '0;
  logic          clear  = 1'b0;

  logic [7:0] code,  code5;
  logic [2:0] index, index5;
  logic       tick,  tick5;
  logic       wrap,  wrap5;

  onehot_digit_sequencer #(.PRESCALE_W(PW), .DIGITS(DIG), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .step(step),
    .period(period), .clear(clear),
    .code(code), .index(index), .tick(tick), .wrap(wrap)
  );

  onehot_digit_sequencer #(.PRESCALE_W(PW), .DIGITS(DIG5), .DEBOUNCE_CYC(DEB)) dut5 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .step(step),
    .period(period), .clear(clear),
    .code(code5), .index(index5), .tick(tick5), .wrap(wrap5)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: integer index with modular stepping, a sample window
  // for the debouncer, and a free-running modular prescaler count.
  // --------------------------------------------------------------------------
  int     m_idx   = 0;
  int     m_tick  = 0;
  int     m_wrap  = 0;
  int     m_mode  = 0;
  longint m_cnt   = 0;
  bit     m_s1    = 0;
  bit     m_s2    = 0;
  bit     m_level = 0;
  bit     m_prev  = 0;
  bit     m_win[$];

  always @(posedge clk or negedge rst_n) begin : ref_model
    int dir;
    int nxt;
    bit press;
    bit flip;
    if (!rst_n) begin
      m_idx = 0; m_tick = 0; m_wrap = 0; m_mode = 0; m_cnt = 0;
      m_s1 = 0; m_s2 = 0; m_level = 0; m_prev = 0;
      m_win.delete();
    end else begin
      press = m_level && !m_prev;
      dir = 0;
      if (ena && !clear) begin
        if      (m_mode == 1 && m_cnt == longint'(period)) dir = 1;
        else if (m_mode == 2 && m_cnt == longint'(period)) dir = -1;
        else if (m_mode == 3 && press)                     dir = 1;
      end
      if (clear) begin
        m_idx = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
      end else if (ena) begin
        m_tick = (dir != 0) ? 1 : 0;
        nxt    = m_idx + dir;
        m_wrap = (nxt < 0 || nxt >= DIG) ? 1 : 0;
        m_idx  = (nxt + DIG) % DIG;
        if (int'(mode) != m_mode)      m_cnt = 0;
        else if (m_mode == 1 || m_mode == 2)
          m_cnt = (m_cnt == longint'(period)) ? 0 : ((m_cnt + 1) % (longint'(1) << PW));
      end else begin
        m_tick = 0; m_wrap = 0;
      end
      if (ena) m_mode = int'(mode);
      // Debounced level flips once the last DEB synchronized samples all
      // disagree with it.
      m_win.push_back(m_s2);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      m_prev = m_level;
      flip = (m_win.size() == DEB);
      foreach (m_win[k]) if (m_win[k] == m_level) flip = 0;
      if (flip) m_level = !m_level;
      m_s2 = m_s1;
      m_s1 = step;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("sb code",  int'(code),  1 << m_idx);
      check("sb index", int'(index), m_idx);
      check("sb tick",  int'(tick),  m_tick);
      check("sb wrap",  int'(wrap),  m_wrap);
    end
  end

  // --------------------------------------------------------------------------
  // Phase table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [1:0]    mode;
    logic [PW-1:0] period;
    logic          ena;
    logic          clear;
    logic          step;
    int            n;
    int            exp_idx;
    int            exp_ticks;
    int            exp_wraps;
  } phase_t;

  phase_t phases[20];

  task automatic run_phase(input phase_t p, input int id);
    int t;
    int w;
    mode = p.mode; period = p.period; ena = p.ena; clear = p.clear; step = p.step;
    t = 0; w = 0;
    repeat (p.n) begin
      @(posedge clk); #1;
      t += int'(tick);
      w += int'(wrap);
    end
    @(negedge clk);
    check($sformatf("phase%0d index", id), int'(index), p.exp_idx);
    check($sformatf("phase%0d ticks", id), t, p.exp_ticks);
    check($sformatf("phase%0d wraps", id), w, p.exp_wraps);
  endtask

  int d5_seq[5];
  int tcount;

  initial begin
    //               mode   period ena clr stp  n  idx tk wr
    phases[0]  = '{2'b01, 24'd3, 1, 0, 0, 33, 0, 8, 1};  // full up cycle 01..80,01
    phases[1]  = '{2'b01, 24'd3, 1, 0, 0,  7, 1, 1, 0};  // ends with cnt at terminal
    phases[2]  = '{2'b01, 24'd3, 1, 1, 0,  1, 0, 0, 0};  // clear on terminal count
    phases[3]  = '{2'b00, 24'd3, 1, 0, 0,  2, 0, 0, 0};
    phases[4]  = '{2'b10, 24'd0, 1, 0, 0,  9, 0, 8, 1};  // 0,7,6,..,1,0 every cycle
    phases[5]  = '{2'b10, 24'd5, 1, 0, 0,  3, 0, 0, 0};  // mid-count
    phases[6]  = '{2'b00, 24'd5, 1, 0, 0, 10, 0, 0, 0};  // HOLD: no more ticks
    phases[7]  = '{2'b10, 24'd1, 1, 0, 0,  3, 7, 1, 1};
    phases[8]  = '{2'b01, 24'd1, 1, 0, 0,  2, 7, 0, 0};  // cnt reaches terminal
    phases[9]  = '{2'b01, 24'd1, 1, 1, 0,  1, 0, 0, 0};  // clear beats wrap at 7
    phases[10] = '{2'b01, 24'd3, 1, 0, 0,  6, 1, 1, 0};  // cnt left at 2
    phases[11] = '{2'b01, 24'd3, 0, 0, 0, 20, 1, 0, 0};  // frozen
    phases[12] = '{2'b01, 24'd3, 1, 0, 0,  1, 1, 0, 0};  // cnt 2->3
    phases[13] = '{2'b01, 24'd3, 1, 0, 0,  1, 2, 1, 0};  // retained count fires
    phases[14] = '{2'b01, 24'd1, 1, 1, 0,  1, 0, 0, 0};
    phases[15] = '{2'b11, 24'd1, 1, 1, 0,  1, 0, 0, 0};
    phases[16] = '{2'b11, 24'd1, 1, 0, 0,  8, 0, 0, 0};
    phases[17] = '{2'b00, 24'd1, 1, 0, 1, 10, 1, 0, 0};  // press in HOLD dropped
    phases[18] = '{2'b00, 24'd1, 1, 0, 0, 10, 1, 0, 0};
    phases[19] = '{2'b01, 24'd0, 1, 0, 0,  5, 5, 4, 0};
    d5_seq = '{2, 4, 8, 16, 1};

    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset code",  int'(code),  8'h01);
    check("reset index", int'(index), 0);
    check("reset tick",  int'(tick),  0);
    check("reset wrap",  int'(wrap),  0);
    check("reset code5", int'(code5), 8'h01);
    rst_n = 1'b1;

    for (int i = 0; i <= 14; i++) run_phase(phases[i], i);

    // DIGITS=5, AUTO_UP, period=1
    mode = 2'b01; period = 24'd1; ena = 1'b1; clear = 1'b0; step = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      check("d5 high bits", int'(code5[7:5]), 0);
      if (e % 2 == 0) begin
        check("d5 code", int'(code5), d5_seq[e/2-1]);
        check("d5 wrap", int'(wrap5), (e == 10) ? 1 : 0);
      end
    end
    @(negedge clk);
    check("main index after d5 run", int'(index), 5);

    run_phase(phases[15], 15);
    run_phase(phases[16], 16);

    // Bouncing press: one-cycle glitch, then stable rise held high
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk); step = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("manual index e%0d", k), int'(index), (k >= 7) ? 1 : 0);
      check($sformatf("manual tick e%0d", k),  int'(tick),  (k == 7) ? 1 : 0);
    end
    @(negedge clk); step = 1'b0;
    tcount = 0;
    repeat (10) begin @(posedge clk); #1; tcount += int'(tick); end
    check("manual release ticks", tcount, 0);
    @(negedge clk);

    for (int i = 17; i <= 19; i++) run_phase(phases[i], i);

    // Asynchronous reset mid-run at index 5
    #2 rst_n = 1'b0;
    #1;
    check("async reset code",  int'(code),  8'h01);
    check("async reset index", int'(index), 0);
    check("async reset code5", int'(code5), 8'h01);
    repeat (2) @(negedge clk);
    mode = 2'b01; period = 24'd2; ena = 1'b1; clear = 1'b0; step = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("post-reset tick e%0d", k), int'(tick), (k == 4) ? 1 : 0);
    end

    // Randomized stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) period = PW'($urandom_range(0, 4));
      ena   = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) step = ~step;
      if (i == 1500) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
